// File: rtl/lane_car_counter_if.sv
// Lane sensor/light inputs and per-lane count outputs shared between the
// intersection controller and the car counter.
interface lane_car_counter_if #(
  parameter int unsigned NUM_LANES = 8,
  parameter int unsigned CNT_W     = 8
);
  logic [NUM_LANES-1:0]       sensor_in;
  logic [NUM_LANES-1:0]       lights;
  logic                       clear_stats;
  logic [NUM_LANES*CNT_W-1:0] carCounts;
  logic [NUM_LANES-1:0]       overflow;
  logic [NUM_LANES-1:0]       depart_pulse;

  modport master (
    output sensor_in, lights, clear_stats,
    input  carCounts, overflow, depart_pulse
  );

  modport slave (
    input  sensor_in, lights, clear_stats,
    output carCounts, overflow, depart_pulse
  );
endinterface

// File: rtl/lane_car_counter.sv
// Per-lane car queue counter: counts synchronised sensor rising edges and
// removes one car per departure slot while the lane light is green.
module lane_car_counter #(
  parameter int unsigned NUM_LANES     = 8,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned START_DELAY   = 2,
  parameter int unsigned DEPART_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  lane_car_counter_if.slave bus
);
  localparam int unsigned TMAX  = (START_DELAY > DEPART_CYCLES) ? START_DELAY : DEPART_CYCLES;
  localparam int unsigned TMR_W = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);

  localparam logic [1:0] RED   = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] FLOW  = 2'd2;

  localparam logic [TMR_W-1:0] START_LD  = TMR_W'(START_DELAY - 1);
  localparam logic [TMR_W-1:0] DEPART_LD = TMR_W'(DEPART_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [NUM_LANES-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_LANES-1:0] arrival, depart;
  logic [1:0]           state_q [NUM_LANES];
  logic [1:0]           state_d [NUM_LANES];
  logic [TMR_W-1:0]     timer_q [NUM_LANES];
  logic [TMR_W-1:0]     timer_d [NUM_LANES];
  logic [CNT_W-1:0]     cnt_q   [NUM_LANES];
  logic [CNT_W-1:0]     cnt_d   [NUM_LANES];
  logic [NUM_LANES-1:0] ovf_q, ovf_d;
  logic [NUM_LANES-1:0] pulse_q, pulse_d;
  logic [NUM_LANES*CNT_W-1:0] counts_flat;

  assign arrival = sync2_q & ~prev_q;

  always_comb begin
    depart      = '0;
    ovf_d       = ovf_q;
    pulse_d     = '0;
    counts_flat = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      cnt_d[i]   = cnt_q[i];
      // Lights are already synchronous to clk; a red light always wins.
      if (!bus.lights[i]) begin
        state_d[i] = RED;
        timer_d[i] = '0;
      end else begin
        case (state_q[i])
          RED: begin
            state_d[i] = START;
            timer_d[i] = START_LD;
          end
          START, FLOW: begin
            if (timer_q[i] != '0) begin
              timer_d[i] = timer_q[i] - TMR_W'(1);
            end else begin
              depart[i]  = 1'b1;
              state_d[i] = FLOW;
              timer_d[i] = DEPART_LD;
            end
          end
          default: begin
            state_d[i] = RED;
            timer_d[i] = '0;
          end
        endcase
      end

      // A simultaneous arrival and departure cancel, so saturation cannot flag.
      if (bus.clear_stats) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (depart[i] && (cnt_q[i] != '0)) begin
        pulse_d[i] = 1'b1;
        if (!arrival[i]) cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end else if (arrival[i]) begin
        if (cnt_q[i] == CNT_MAX) ovf_d[i] = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end

      counts_flat[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      ovf_q   <= '0;
      pulse_q <= '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= RED;
        timer_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      sync1_q <= bus.sensor_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      ovf_q   <= ovf_d;
      pulse_q <= pulse_d;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.carCounts    = counts_flat;
  assign bus.overflow     = ovf_q;
  assign bus.depart_pulse = pulse_q;
endmodule

// File: tb/tb_lane_car_counter.sv
// Directed checks of arrival counting, green-light draining, saturation,
// clear, reset and short-green behaviour of lane_car_counter.
module tb_lane_car_counter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  lane_car_counter_if #(.NUM_LANES(8), .CNT_W(8)) bus ();

  lane_car_counter #(
    .NUM_LANES(8), .CNT_W(8), .START_DELAY(2), .DEPART_CYCLES(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [7:0] lane_cnt(input int lane);
    return bus.carCounts[lane*8 +: 8];
  endfunction

  // n one-cycle-high pulses, then enough cycles for the last one to land.
  task automatic pulse(input int lane, input int n);
    repeat (n) begin
      bus.sensor_in[lane] = 1'b1;
      step(1);
      bus.sensor_in[lane] = 1'b0;
      step(1);
    end
    step(2);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n            = 1'b0;
    bus.sensor_in    = '0;
    bus.lights       = '0;
    bus.clear_stats  = 1'b0;
    #23;
    check("reset_counts", bus.carCounts, 64'h0);
    check("reset_ovf", {56'h0, bus.overflow}, 64'h0);
    check("reset_pulse", {56'h0, bus.depart_pulse}, 64'h0);
    rst_n = 1'b1;
    step(2);

    // Arrival latency: first sampled at edge k, counted at edge k+2.
    bus.sensor_in[5] = 1'b1;
    step(2);
    check("lat_k1", {56'h0, lane_cnt(5)}, 64'd0);
    step(1);
    check("lat_k2", {56'h0, lane_cnt(5)}, 64'd1);
    bus.sensor_in[5] = 1'b0;
    step(2);

    // Five 2-high/2-low pulses on lane 2.
    repeat (5) begin
      bus.sensor_in[2] = 1'b1;
      step(2);
      bus.sensor_in[2] = 1'b0;
      step(2);
    end
    step(2);
    check("arr_lane2", bus.carCounts, 64'h0000_0100_0005_0000);

    bus.sensor_in[1] = 1'b1;
    step(10);
    check("held_high", {56'h0, lane_cnt(1)}, 64'd1);
    bus.sensor_in[1] = 1'b0;
    step(3);
    check("held_all", bus.carCounts, 64'h0000_0100_0005_0100);

    // Reset while lane 0 is draining.
    pulse(0, 3);
    bus.lights = 8'h01;
    step(3);
    check("pre_rst_cnt", {56'h0, lane_cnt(0)}, 64'd2);
    check("pre_rst_pulse", {56'h0, bus.depart_pulse}, 64'h01);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_counts", bus.carCounts, 64'h0);
    check("midrst_pulse", {56'h0, bus.depart_pulse}, 64'h0);
    check("midrst_ovf", {56'h0, bus.overflow}, 64'h0);
    bus.lights = '0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Drain: first departure at e+2, then e+6, e+10, none at e+14.
    pulse(0, 3);
    check("drain_init", {56'h0, lane_cnt(0)}, 64'd3);
    bus.lights = 8'h01;
    step(1);
    check("drain_e0", {56'h0, lane_cnt(0)}, 64'd3);
    step(1);
    check("drain_e1", {48'h0, lane_cnt(0), bus.depart_pulse}, {48'h0, 8'd3, 8'h00});
    step(1);
    check("drain_e2", {48'h0, lane_cnt(0), bus.depart_pulse}, {48'h0, 8'd2, 8'h01});
    step(1);
    check("drain_e3", {56'h0, bus.depart_pulse}, 64'h0);
    step(3);
    check("drain_e6", {48'h0, lane_cnt(0), bus.depart_pulse}, {48'h0, 8'd1, 8'h01});
    step(4);
    check("drain_e10", {48'h0, lane_cnt(0), bus.depart_pulse}, {48'h0, 8'd0, 8'h01});
    step(4);
    check("drain_e14", {48'h0, lane_cnt(0), bus.depart_pulse}, {48'h0, 8'd0, 8'h00});
    bus.lights = '0;
    step(1);

    // Saturation on lane 7, then clear.
    pulse(7, 255);
    check("sat_255", {48'h0, lane_cnt(7), bus.overflow}, {48'h0, 8'd255, 8'h00});
    pulse(7, 2);
    check("sat_ovf", {48'h0, lane_cnt(7), bus.overflow}, {48'h0, 8'd255, 8'h80});
    bus.clear_stats = 1'b1;
    step(1);
    bus.clear_stats = 1'b0;
    check("clear", {48'h0, lane_cnt(7), bus.overflow}, {48'h0, 8'd0, 8'h00});

    // Arrival coinciding with departure on lane 4.
    pulse(4, 1);
    bus.lights       = 8'h10;
    bus.sensor_in[4] = 1'b1;
    step(2);
    check("sim1_e1", {48'h0, lane_cnt(4), bus.depart_pulse}, {48'h0, 8'd1, 8'h00});
    step(1);
    check("sim1_e2", {48'h0, lane_cnt(4), bus.depart_pulse}, {48'h0, 8'd1, 8'h10});
    bus.lights       = '0;
    bus.sensor_in[4] = 1'b0;
    step(3);
    pulse(4, 254);
    check("sim255_init", {56'h0, lane_cnt(4)}, 64'd255);
    bus.lights       = 8'h10;
    bus.sensor_in[4] = 1'b1;
    step(3);
    check("sim255_e2", {40'h0, lane_cnt(4), bus.depart_pulse, bus.overflow},
          {40'h0, 8'd255, 8'h10, 8'h00});
    bus.lights       = '0;
    bus.sensor_in[4] = 1'b0;
    step(3);
    check("sim255_ovf", {56'h0, bus.overflow}, 64'h0);

    // One-cycle green on lane 3, then a proper green.
    pulse(3, 2);
    bus.lights = 8'h08;
    step(1);
    bus.lights = '0;
    step(3);
    check("short_green", {48'h0, lane_cnt(3), bus.depart_pulse}, {48'h0, 8'd2, 8'h00});
    bus.lights = 8'h08;
    step(2);
    check("regreen_e1", {48'h0, lane_cnt(3), bus.depart_pulse}, {48'h0, 8'd2, 8'h00});
    step(1);
    check("regreen_e2", {48'h0, lane_cnt(3), bus.depart_pulse}, {48'h0, 8'd1, 8'h08});
    bus.lights = '0;
    step(2);
    check("final_counts", bus.carCounts, 64'h0000_00FF_0100_0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
